// File: rtl/sine_pkg.sv
// -----------------------------------------------------------------------------
// sine_pkg
// Shared types and helpers for the sine ROM address generator.
//   state_t : control FSM states (IDLE, RUN, STOPPING)
//   addr_w  : ROM address width for a given number of entries
// -----------------------------------------------------------------------------
package sine_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // Address bits needed to index DEPTH entries; a single-entry ROM still
  // gets one address bit so port widths never collapse to zero.
  function automatic int addr_w(input int depth);
    if (depth <= 1) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/sine_addr_gen_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Sample-rate divider: produces a tick every div+1 cycles while enabled.
// The divisor is captured only when the run is (re)started from idle.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart counter and capture div
//   enable     : count while high (generator busy)
//   div        : divisor, tick period = div+1 cycles
//   tick       : one-cycle strobe when the counter reaches the divisor
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] div_q_r;

  assign tick = enable && (cnt_r == div_q_r);

  // Counter and captured divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {DIV_WIDTH{1'b0}};
      div_q_r <= {DIV_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r   <= {DIV_WIDTH{1'b0}};
      div_q_r <= div;
    end else if (enable) begin
      if (tick) begin
        cnt_r <= {DIV_WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sine_addr_gen.sv
// -----------------------------------------------------------------------------
// sine_addr_gen
// Phase-accumulator address generator driving a registered sine ROM.
// Each sample tick steps the accumulator by the tuning word and presents
// the top accumulator bits as the ROM address.
//   clk, rst_n   : clock, async active-low reset
//   start, stop  : level controls (start begins, stop ends at period end)
//   tune_word    : phase increment per tick (adopted at period boundaries)
//   div          : tick every div+1 cycles (captured at start)
//   rom_en       : ROM read strobe, one cycle per tick
//   rom_addr     : ROM address, valid with rom_en
//   sample_valid : ROM data valid (rom_en delayed one cycle)
//   wrap         : with rom_en when this step overflows the accumulator
//   busy         : generator in RUN or STOPPING
// -----------------------------------------------------------------------------
module sine_addr_gen
  import sine_pkg::*;
#(
  parameter  int DEPTH     = 64,
  parameter  int ACC_WIDTH = 16,
  parameter  int DIV_WIDTH = 16,
  localparam int AW        = addr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [ACC_WIDTH-1:0] tune_word,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  output logic                 sample_valid,
  output logic                 wrap,
  output logic                 busy
);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] tune_q_r;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 carry_s;
  logic                 tick_s;
  logic                 start_idle_s;
  logic                 running_s;
  logic                 rom_en_r;
  logic [AW-1:0]        rom_addr_r;
  logic                 sample_valid_r;
  logic                 wrap_r;
  logic                 busy_r;

  assign sum_s        = {1'b0, acc_r} + {1'b0, tune_q_r};
  assign carry_s      = sum_s[ACC_WIDTH];
  assign start_idle_s = (state_r == IDLE) && start;
  assign running_s    = (state_r != IDLE);

  assign rom_en       = rom_en_r;
  assign rom_addr     = rom_addr_r;
  assign sample_valid = sample_valid_r;
  assign wrap         = wrap_r;
  assign busy         = busy_r;

  tick_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_idle_s),
    .enable (running_s),
    .div    (div),
    .tick   (tick_s)
  );

  // Next-state logic of the run/stop controller
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt_s = STOPPING;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STOPPING: begin
        // A zero tuning word never wraps, so there is no period end to wait for.
        if (start) begin
          state_nxt_s = RUN;
        end else if (tune_q_r == {ACC_WIDTH{1'b0}}) begin
          state_nxt_s = IDLE;
        end else if (tick_s && carry_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOPPING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, accumulator and registered ROM-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      acc_r          <= {ACC_WIDTH{1'b0}};
      tune_q_r       <= {ACC_WIDTH{1'b0}};
      rom_en_r       <= 1'b0;
      rom_addr_r     <= {AW{1'b0}};
      wrap_r         <= 1'b0;
      sample_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      busy_r         <= (state_nxt_s != IDLE);
      sample_valid_r <= rom_en_r;
      if (start_idle_s) begin
        acc_r    <= {ACC_WIDTH{1'b0}};
        tune_q_r <= tune_word;
        rom_en_r <= 1'b0;
        wrap_r   <= 1'b0;
      end else if (tick_s) begin
        rom_en_r   <= 1'b1;
        rom_addr_r <= acc_r[ACC_WIDTH-1 -: AW];
        acc_r      <= sum_s[ACC_WIDTH-1:0];
        wrap_r     <= carry_s;
        // New frequency only takes effect at a period boundary (glitch-free).
        if (carry_s) begin
          tune_q_r <= tune_word;
        end
      end else begin
        rom_en_r <= 1'b0;
        wrap_r   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_sine_addr_gen
// Drives sine_addr_gen into a registered ROM model. Expected (addr, wrap)
// pairs come from a phase-accumulator model and are queued before each run;
// every rom_en pops one entry, and ROM data is checked on sample_valid.
// -----------------------------------------------------------------------------
module tb_sine_addr_gen;

  localparam int DEPTH     = 64;
  localparam int ACC_WIDTH = 16;
  localparam int DIV_WIDTH = 16;
  localparam int AW        = 6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wrap;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 stop;
  logic [ACC_WIDTH-1:0] tune_word;
  logic [DIV_WIDTH-1:0] div;
  logic                 rom_en;
  logic [AW-1:0]        rom_addr;
  logic                 sample_valid;
  logic                 wrap;
  logic                 busy;
  logic [7:0]           rom_data;

  exp_t    sb_q[$];
  int      n_cmp;
  int      n_bad;
  int      cyc;
  int      run_id;
  int      last_run;
  int      last_cyc;
  int      exp_gap;
  int      m_acc;
  logic    prev_en;
  logic [AW-1:0] last_addr;

  sine_addr_gen #(
    .DEPTH     (DEPTH),
    .ACC_WIDTH (ACC_WIDTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .tune_word    (tune_word),
    .div          (div),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .sample_valid (sample_valid),
    .wrap         (wrap),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
    return {a, 2'b10} ^ 8'h5A;
  endfunction

  // Registered ROM with one-cycle read latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_fn(rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue one full sine period (up to and including the wrapping step).
  task automatic push_period(input int tune);
    exp_t e;
    int   s;
    int   guard;
    e = '0;
    guard = 0;
    do begin
      e.addr = AW'(m_acc >> (ACC_WIDTH - AW));
      s      = m_acc + tune;
      e.wrap = (s >= 65536);
      m_acc  = s & 32'h0000_FFFF;
      sb_q.push_back(e);
      guard++;
    end while (!e.wrap && guard < 1000);
  endtask

  // Advance to the next falling edge and check the outputs there.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      chk("sample_valid_lag", 32'(sample_valid), 32'(prev_en));
      if (sample_valid === 1'b1 && prev_en === 1'b1)
        chk("rom_data", 32'(rom_data), 32'(rom_fn(last_addr)));
      if (rom_en === 1'b1) begin
        chk("rom_en_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("rom_addr", 32'(rom_addr), 32'(e.addr));
          chk("wrap", 32'(wrap), 32'(e.wrap));
          if (exp_gap != 0 && last_run == run_id)
            chk("tick_gap", 32'(cyc - last_cyc), 32'(exp_gap));
          last_cyc  = cyc;
          last_run  = run_id;
          last_addr = e.addr;
        end
      end else begin
        chk("wrap_without_en", 32'(wrap), 32'd0);
      end
      prev_en = rom_en;
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_run(input int tune, input int dv, input logic stp);
    start     = 1'b1;
    stop      = stp;
    tune_word = ACC_WIDTH'(tune);
    div       = DIV_WIDTH'(dv);
    run_id++;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (sb_q.size() == 0 && busy === 1'b0 && rom_en === 1'b0) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
    step_n(6);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; run_id = 0; last_run = -1; last_cyc = 0;
    exp_gap = 0; m_acc = 0; prev_en = 1'b0; last_addr = '0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tune_word = '0; div = '0;

    // Reset state
    step_n(2);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;
    step_n(3);

    // Basic sweep: two periods, latency and busy checks
    m_acc = 0; push_period(32'h0400); push_period(32'h0400);
    exp_gap = 1;
    start_run(32'h0400, 0, 1'b0);
    chk("lat_first_cycle_rom_en", 32'(rom_en), 32'd0);
    step();
    chk("lat_rom_en", 32'(rom_en), 32'd1);
    chk("lat_rom_addr", 32'(rom_addr), 32'd0);
    step();
    chk("lat_sample_valid", 32'(sample_valid), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    step_n(66);
    stop = 1'b1;
    wait_idle("sweep_idle", 200);
    stop = 1'b0;

    // Divider: one tick per 4 cycles
    m_acc = 0; push_period(32'h0400);
    exp_gap = 4;
    start_run(32'h0400, 3, 1'b0);
    step_n(20);
    stop = 1'b1;
    wait_idle("div_idle", 400);
    stop = 1'b0;

    // Fractional step; start+stop together in IDLE (start wins, one period)
    m_acc = 0; push_period(32'h0600);
    exp_gap = 1;
    start_run(32'h0600, 0, 1'b1);
    chk("start_wins_busy", 32'(busy), 32'd1);
    wait_idle("frac_idle", 200);
    stop = 1'b0;

    // Frequency change mid-period takes effect only after the wrap
    m_acc = 0; push_period(32'h0400); push_period(32'h0800);
    exp_gap = 1;
    start_run(32'h0400, 0, 1'b0);
    step_n(21);
    tune_word = 16'h0800;
    step_n(60);
    stop = 1'b1;
    wait_idle("freq_idle", 200);
    stop = 1'b0;
    tune_word = 16'h0400;

    // Graceful stop, then resume from STOPPING without a gap
    m_acc = 0; push_period(32'h0400); push_period(32'h0400);
    exp_gap = 1;
    start_run(32'h0400, 0, 1'b0);
    step_n(11);
    stop = 1'b1;
    step_n(3);
    chk("stopping_busy", 32'(busy), 32'd1);
    step_n(17);
    stop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(50);
    stop = 1'b1;
    wait_idle("resume_idle", 200);
    stop = 1'b0;

    // Asynchronous reset mid-run, then a fresh run from address 0
    m_acc = 0; push_period(32'h0400);
    exp_gap = 1;
    start_run(32'h0400, 0, 1'b0);
    step_n(30);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    sb_q.delete();
    step();
    #2 rst_n = 1'b1;
    step_n(8);
    m_acc = 0; push_period(32'h0400);
    start_run(32'h0400, 0, 1'b1);
    wait_idle("post_reset_idle", 200);
    stop = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
